// File: rtl/mat_stream_host_pkg.sv
// Shared constants and state encoding for the matrix stream host.
// The values match the stream constants of the bidiagonalization core.
package mat_stream_host_pkg;

    localparam int BIT_NUM      = 18;
    localparam int CHANNEL_SIZE = 16;
    localparam int TIMEOUT_CYC  = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_COLLECT = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // IDLE and DONE are the only states where the host may load and start.
    function automatic logic is_quiet(state_e s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/mat_stream_host_if.sv
// Serial sample stream between the host and the core.
// Handshake: valid-only, no back-pressure. A beat transfers on every rising
// clk edge where valid is 1; R/I are meaningful only while valid is 1.
interface mat_stream_host_if
    import mat_stream_host_pkg::*;
#(
    parameter int W = BIT_NUM
) ();
    logic                tx_valid;
    logic signed [W-1:0] tx_R;
    logic signed [W-1:0] tx_I;
    logic                rx_valid;
    logic signed [W-1:0] rx_R;
    logic signed [W-1:0] rx_I;

    // Host side: drives the core input, observes the core output.
    modport master (
        output tx_valid, tx_R, tx_I,
        input  rx_valid, rx_R, rx_I
    );

    // Core side: the mirror image.
    modport slave (
        input  tx_valid, tx_R, tx_I,
        output rx_valid, rx_R, rx_I
    );
endinterface

// File: rtl/mat_stream_host_cplx_buf16.sv
// 16-entry complex register file: one synchronous write port and one
// registered read port. rd_zero forces the read register to 0 so the
// consumer gets a clean zero without a mux after the flop.
module cplx_buf16 #(
    parameter int W = 18
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [3:0]          wr_addr,
    input  logic signed [W-1:0] wr_R,
    input  logic signed [W-1:0] wr_I,
    input  logic [3:0]          rd_addr,
    input  logic                rd_zero,
    output logic signed [W-1:0] rd_R,
    output logic signed [W-1:0] rd_I
);
    logic signed [W-1:0] mem_r_q [16];
    logic signed [W-1:0] mem_r_d [16];
    logic signed [W-1:0] mem_i_q [16];
    logic signed [W-1:0] mem_i_d [16];
    logic signed [W-1:0] rd_r_q, rd_r_d;
    logic signed [W-1:0] rd_i_q, rd_i_d;

    // Next contents and read data; the read sees the pre-write contents.
    always_comb begin
        mem_r_d = mem_r_q;
        mem_i_d = mem_i_q;
        if (we) begin
            mem_r_d[wr_addr] = wr_R;
            mem_i_d[wr_addr] = wr_I;
        end
        rd_r_d = rd_zero ? '0 : mem_r_q[rd_addr];
        rd_i_d = rd_zero ? '0 : mem_i_q[rd_addr];
    end

    // Storage and read register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem_r_q[i] <= '0;
                mem_i_q[i] <= '0;
            end
            rd_r_q <= '0;
            rd_i_q <= '0;
        end else begin
            mem_r_q <= mem_r_d;
            mem_i_q <= mem_i_d;
            rd_r_q  <= rd_r_d;
            rd_i_q  <= rd_i_d;
        end
    end

    assign rd_R = rd_r_q;
    assign rd_I = rd_i_q;
endmodule

// File: rtl/mat_stream_host.sv
// Host-side peer of the 4x4 complex bidiagonalization core: streams the
// loaded TX matrix (after a mandatory zero header beat) and captures the
// 16-beat result burst into the RX buffer for random-access readout.
module mat_stream_host
    import mat_stream_host_pkg::*;
#(
    parameter int BIT_NUM      = mat_stream_host_pkg::BIT_NUM,
    parameter int CHANNEL_SIZE = mat_stream_host_pkg::CHANNEL_SIZE,
    parameter int TIMEOUT_CYC  = mat_stream_host_pkg::TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ld_we,
    input  logic [3:0]                ld_addr,
    input  logic signed [BIT_NUM-1:0] ld_R,
    input  logic signed [BIT_NUM-1:0] ld_I,
    input  logic                      start,
    mat_stream_host_if.master         strm,
    input  logic [3:0]                rd_addr,
    output logic signed [BIT_NUM-1:0] rd_R,
    output logic signed [BIT_NUM-1:0] rd_I,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [2:0]                dbg_state
);
    localparam int          TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);
    localparam logic [4:0]  LAST    = 5'(CHANNEL_SIZE - 1);

    state_e        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_we, tx_rd_zero;
    logic [3:0]    tx_rd_addr;
    logic          rx_we;
    logic [3:0]    rx_waddr;

    // State, counters and registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    // Next state, counters, error and RX capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        rx_we    = 1'b0;
        rx_waddr = cnt_q[3:0];
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_PRE;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_PRE: begin
                state_d = ST_SEND;
                cnt_d   = '0;
            end
            ST_SEND: begin
                if (cnt_q == LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_WAIT: begin
                if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
                if (strm.rx_valid) begin
                    rx_we    = 1'b1;
                    rx_waddr = 4'd0;
                    cnt_d    = 5'd1;
                    state_d  = ST_COLLECT;
                end else if (tmo_d == TMO_MAX) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_COLLECT: begin
                if (strm.rx_valid) begin
                    rx_we = 1'b1;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST) state_d = ST_DONE;
                end else begin
                    // Short burst: keep what arrived, flag it.
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered-output precompute from the next state, plus TX buffer control.
    always_comb begin
        tx_valid_d = (state_d == ST_PRE) || (state_d == ST_SEND);
        tx_rd_zero = (state_d != ST_SEND);
        tx_rd_addr = cnt_d[3:0];
        busy_d     = !is_quiet(state_d);
        done_d     = (state_d == ST_DONE) && (state_q != ST_DONE);
        tx_we      = ld_we && is_quiet(state_q);
    end

    cplx_buf16 #(.W(BIT_NUM)) u_tx_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (tx_we),
        .wr_addr (ld_addr),
        .wr_R    (ld_R),
        .wr_I    (ld_I),
        .rd_addr (tx_rd_addr),
        .rd_zero (tx_rd_zero),
        .rd_R    (strm.tx_R),
        .rd_I    (strm.tx_I)
    );

    cplx_buf16 #(.W(BIT_NUM)) u_rx_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rx_we),
        .wr_addr (rx_waddr),
        .wr_R    (strm.rx_R),
        .wr_I    (strm.rx_I),
        .rd_addr (rd_addr),
        .rd_zero (1'b0),
        .rd_R    (rd_R),
        .rd_I    (rd_I)
    );

    assign strm.tx_valid = tx_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign dbg_state     = state_q;
endmodule
